ex_muldiv_seq: RTL and testbench
================================

Name: ex_muldiv_seq

Overview:
- Execute-stage sequencer for RV32M multiply/divide ops.
- Runs a 32-iteration shift-add multiply or restoring divide using an internal 33-bit add/sub datapath.
- Holds the pipeline via `stall` while the single-cycle ALU continues to serve all other ops.
- Sits beside the ALU in Execute; the result is muxed into the EX/MEM register on `done`.

Parameters:
- `XLEN`, 32, operand/result width (only 32 is supported).
- `CNT_W`, 5, iteration counter width; must satisfy 2**CNT_W == XLEN.

Ports:
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  synchronous reset, active-high.
- `start`  input  1  request from Execute; valid instruction is an M-op.
- `op`  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `A`  input  32  rs1 operand (post-forwarding).
- `B`  input  32  rs2 operand (post-forwarding).
- `flush`  input  1  pipeline flush of the EX instruction; aborts the op.
- `stall`  output  1  freeze IF/ID/EX; combinational.
- `busy`  output  1  FSM not IDLE; registered.
- `done`  output  1  one-cycle pulse; `result` valid.
- `result`  output  32  final value; held until the next accepted start.

Behaviour:
- Reset values: state=IDLE, `busy`=0, `done`=0, `result`=0, counter=0, internal regs=0.
- States and transitions:
  - IDLE: `start` & ~`flush` -> CALC. On entry to CALC:
    - latch `op`;
    - latch operand magnitudes: signed ops take |A|/|B| and record result sign; MULHSU treats only A as signed;
    - counter=31.
  - CALC: one iteration per cycle.
    - Multiply: conditional add of the multiplicand into the high half of the 64-bit product, then shift right.
    - Divide: shift remainder left, trial subtract the divisor; keep the result if non-negative and set quotient bit.
    - counter==0 -> FIX, else counter-1.
  - FIX: apply sign correction via two's-complement negate. Select the output:
    - MUL -> low 32 bits;
    - MULH/MULHSU/MULHU -> high 32 bits;
    - DIV/DIVU -> quotient;
    - REM/REMU -> remainder.
    - Then -> DONE, registering `result`.
  - DONE: `done`=1 for exactly this cycle -> IDLE.
- Latency: start sampled in cycle 0; `done` high in cycle 34 (1 accept + 32 CALC + 1 FIX).
- `stall` = (state==IDLE & `start` & ~`flush`) | state==CALC | state==FIX. It is low in DONE so the pipeline advances and captures `result` in the same edge.
- `start` while not IDLE: ignored; no re-latch of operands.
- `flush` in any non-IDLE state -> IDLE next cycle. No `done`; `result` unchanged.
- `rst` mid-op: same as flush, plus all regs return to reset values.
- Divide by zero:
  - DIV/DIVU quotient = 0xFFFFFFFF;
  - REM/REMU remainder = A.
- Signed overflow (A=0x80000000, B=0xFFFFFFFF):
  - DIV -> 0x80000000;
  - REM -> 0.
- Remainder sign follows the dividend. Quotient sign = sign(A) XOR sign(B), suppressed when B=0.
- All arithmetic is modulo 2^32 on output. The internal subtractor is 33 bits to catch borrow.

Optional Feature:
- Macro: `MULDIV_EARLY_OUT_EN`.
- Defined: in IDLE, if the accepted op is a divide with B==0 or signed overflow, or a multiply with A==0 or B==0, go directly to DONE with the architecturally correct result. `done` arrives in cycle 1; `stall` is high only in cycle 0.
- Undefined: every op takes the full 34-cycle path. Results are identical.

Test Plan:
- MUL A=7, B=0xFFFFFFFA (-6), op=000 -> `done` in cycle 34, `result`=0xFFFFFFD6; `stall` high cycles 0-33, low in 34.
- MULHU A=0xFFFFFFFF, B=0xFFFFFFFF -> `result`=0xFFFFFFFE. Same operands with MULH -> 0x00000000. MULHSU -> 0xFFFFFFFF.
- DIV A=-20 (0xFFFFFFEC), B=3 -> 0xFFFFFFFA (-6). REM same operands -> 0xFFFFFFFE (-2). DIVU 20/3 -> 6.
- DIVU A=0x1234, B=0 -> 0xFFFFFFFF. REMU same operands -> 0x1234. DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000. Check `done` in cycle 34 without the macro, cycle 1 with it.
- DIV started, `flush` asserted in cycle 10 -> IDLE in cycle 11, no `done`, `result` retains the prior value, `stall` low from cycle 11. A new start in cycle 12 completes in cycle 46.
- `rst` pulsed in cycle 20 of a MUL -> `busy`=0, `result`=0 next cycle. A second `start` during CALC with different operands is ignored and the first op's result is returned.

Source files
------------

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative RV32M multiply/divide sequencer for the Execute stage.
// Runs a 32-step shift-add multiply or restoring divide and holds the pipeline
// through `stall` until `result` is ready.
// Optional build macro: MULDIV_EARLY_OUT_EN (trivial operands finish in one cycle).
module ex_muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state, state_n;
    logic [2:0]          op_q;
    logic [XLEN-1:0]     hi, lo, mc;
    logic                neg;
    logic [CNT_W-1:0]    cnt;

    logic                a_sgn, b_sgn, a_neg, b_neg, neg_n;
    logic [XLEN-1:0]     a_abs, b_abs;
    logic [XLEN:0]       add_x, add_y, sum;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     dv_sel, res_fix, res_n;
    logic                load_res, accept;

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    // Operand signedness and magnitudes for the op being accepted
    always_comb begin
        a_sgn = ~op[0] | (op == 3'b001);
        b_sgn = (~op[1] & ~op[2]) | (op[2] & ~op[0]);
        a_neg = a_sgn & A[XLEN-1];
        b_neg = b_sgn & B[XLEN-1];
        a_abs = neg_if(A, a_neg);
        b_abs = neg_if(B, b_neg);
        if (!op[2])
            neg_n = a_neg ^ b_neg;
        else if (!op[1])
            neg_n = (a_neg ^ b_neg) & (B != '0);
        else
            neg_n = a_neg;
    end

    // Shared 33-bit adder: add for multiply, trial subtract for divide
    always_comb begin
        if (!op_q[2]) begin
            add_x = {1'b0, hi};
            add_y = lo[0] ? {1'b0, mc} : '0;
            sum   = add_x + add_y;
        end else begin
            add_x = {hi, lo[XLEN-1]};
            add_y = {1'b0, mc};
            sum   = add_x - add_y;
        end
    end

    // Sign correction and output selection
    always_comb begin
        prod   = {hi, lo};
        prod   = neg ? (~prod + 1'b1) : prod;
        dv_sel = neg_if(op_q[1] ? hi : lo, neg);
        if (!op_q[2])
            res_fix = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        else
            res_fix = dv_sel;
    end

    // Next-state, stall and result-load decode
    always_comb begin
        state_n  = state;
        stall    = 1'b0;
        load_res = 1'b0;
        res_n    = res_fix;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !flush) begin
                    stall = 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                    if (op[2] && (B == '0)) begin
                        state_n  = DONE;
                        load_res = 1'b1;
                        res_n    = op[1] ? A : '1;
                    end else if (op[2] && !op[0] && (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1)) begin
                        state_n  = DONE;
                        load_res = 1'b1;
                        res_n    = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                    end else if (!op[2] && ((A == '0) || (B == '0))) begin
                        state_n  = DONE;
                        load_res = 1'b1;
                        res_n    = '0;
                    end else begin
                        state_n = CALC;
                        accept  = 1'b1;
                    end
`else
                    state_n = CALC;
                    accept  = 1'b1;
`endif
                end
            end
            CALC: begin
                stall = 1'b1;
                if (flush)
                    state_n = IDLE;
                else if (cnt == '0)
                    state_n = FIX;
            end
            FIX: begin
                stall = 1'b1;
                if (flush) begin
                    state_n = IDLE;
                end else begin
                    state_n  = DONE;
                    load_res = 1'b1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Control registers and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            state <= state_n;
            busy  <= (state_n != IDLE);
            done  <= (state_n == DONE);
            if (load_res)
                result <= res_n;
        end
    end

    // Operand latch on accept, one shift-add / restoring-divide step per CALC cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q <= '0;
            hi   <= '0;
            lo   <= '0;
            mc   <= '0;
            neg  <= 1'b0;
            cnt  <= '0;
        end else if (accept) begin
            op_q <= op;
            hi   <= '0;
            lo   <= op[2] ? a_abs : b_abs;
            mc   <= op[2] ? b_abs : a_abs;
            neg  <= neg_n;
            cnt  <= CNT_W'(XLEN - 1);
        end else if (state == CALC && !flush) begin
            cnt <= cnt - 1'b1;
            if (!op_q[2]) begin
                hi <= sum[XLEN:1];
                lo <= {sum[0], lo[XLEN-1:1]};
            end else begin
                hi <= sum[XLEN] ? add_x[XLEN-1:0] : sum[XLEN-1:0];
                lo <= {lo[XLEN-2:0], ~sum[XLEN]};
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb_ex_muldiv_seq: directed and randomized checks of ex_muldiv_seq against a
// plain-arithmetic RV32M reference model.
module tb_ex_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        stall, busy, done;
    logic [31:0] result;

    int nchk = 0;
    int nerr = 0;

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    ex_muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(a), .B(b),
        .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, ps;
        logic [63:0]        ux, uy, pu;
        logic               ovf;
        sx  = {{32{x[31]}}, x};
        sy  = {{32{y[31]}}, y};
        ux  = {32'b0, x};
        uy  = {32'b0, y};
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin ps = sx * sy; return ps[31:0]; end
            3'd1: begin ps = sx * sy; return ps[63:32]; end
            3'd2: begin ps = sx * $signed(uy); return ps[63:32]; end
            3'd3: begin pu = ux * uy; return pu[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                ps = sx / sy; return ps[31:0];
            end
            3'd5: begin
                if (y == 0) return 32'hFFFF_FFFF;
                return x / y;
            end
            3'd6: begin
                if (y == 0) return x;
                if (ovf) return 32'h0;
                ps = sx % sy; return ps[31:0];
            end
            default: begin
                if (y == 0) return x;
                return x % y;
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        bit trivial;
        if (o[2])
            trivial = (y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
        else
            trivial = (x == 0) || (y == 0);
        return (EARLY && trivial) ? 1 : 34;
    endfunction

    // Issue one op in the current cycle; optionally fire a second start at cycle rcyc.
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int rcyc, output logic [31:0] res, output int lat);
        int bad_stall;
        bad_stall = 0;
        lat = -1;
        res = 'x;
        start = 1'b1; op = o; a = x; b = y;
        #1;
        chk("stall_cycle0", {31'b0, stall}, 32'd1);
        tick;
        start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (c == rcyc) begin
                start = 1'b1; op = o ^ 3'b100; a = ~x; b = y + 32'd5;
            end else begin
                start = 1'b0;
            end
            #1;
            if (done) begin
                lat = c;
                res = result;
                chk("stall_at_done", {31'b0, stall}, 32'd0);
                break;
            end
            if (!stall) bad_stall++;
            tick;
        end
        start = 1'b0;
        if (lat < 0) chk("done_timeout", 32'd0, 32'd1);
        chk("stall_while_busy", 32'(bad_stall), 32'd0);
        tick;
    endtask

    typedef struct packed {
        logic [2:0]  o;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] e;
    } vec_t;

    localparam int ND = 14;
    vec_t dv[ND] = '{
        '{3'd0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6},
        '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000},
        '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
        '{3'd4, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA},
        '{3'd6, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE},
        '{3'd5, 32'd20,         32'd3,         32'd6},
        '{3'd5, 32'h1234,       32'd0,         32'hFFFF_FFFF},
        '{3'd7, 32'h1234,       32'd0,         32'h1234},
        '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
        '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0},
        '{3'd4, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF},
        '{3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9},
        '{3'd0, 32'd0,          32'd12345,     32'd0}
    };

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] res, prev, x, y;
        logic [2:0]  o;
        int          lat, rcyc, seen_done;

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) tick;
        rst = 1'b0;
        #1;
        chk("reset_busy",   {31'b0, busy},  32'd0);
        chk("reset_done",   {31'b0, done},  32'd0);
        chk("reset_stall",  {31'b0, stall}, 32'd0);
        chk("reset_result", result,         32'd0);
        tick;

        // Directed vectors with known answers
        for (int i = 0; i < ND; i++) begin
            do_op(dv[i].o, dv[i].x, dv[i].y, 0, res, lat);
            chk($sformatf("dir%0d_result", i), res, dv[i].e);
            chk($sformatf("dir%0d_latency", i), 32'(lat), 32'(exp_lat(dv[i].o, dv[i].x, dv[i].y)));
        end

        // Randomized ops, some with a stray start during the computation
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            x = rnd_operand();
            y = rnd_operand();
            rcyc = (exp_lat(o, x, y) == 34 && (i % 4 == 0)) ? $urandom_range(1, 30) : 0;
            do_op(o, x, y, rcyc, res, lat);
            chk($sformatf("rnd%0d_op%0d_result", i, o), res, ref_md(o, x, y));
            chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(exp_lat(o, x, y)));
        end

        // Flush in cycle 10 of a divide
        do_op(3'd0, 32'd11, 32'd13, 0, prev, lat);
        chk("pre_flush_result", prev, 32'd143);
        seen_done = 0;
        start = 1'b1; op = 3'd4; a = 32'd1000000; b = 32'd7;
        tick;
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (done) seen_done++;
            tick;
        end
        flush = 1'b1;
        #1;
        chk("flush_cycle10_stall", {31'b0, stall}, 32'd1);
        if (done) seen_done++;
        tick;
        flush = 1'b0;
        #1;
        chk("flush_busy",   {31'b0, busy},  32'd0);
        chk("flush_stall",  {31'b0, stall}, 32'd0);
        if (done) seen_done++;
        chk("flush_no_done", 32'(seen_done), 32'd0);
        chk("flush_result_kept", result, prev);
        tick;
        do_op(3'd5, 32'd1000000, 32'd7, 0, res, lat);
        chk("post_flush_result",  res, 32'd142857);
        chk("post_flush_latency", 32'(lat), 32'd34);

        // Reset pulsed in cycle 20 of a multiply
        start = 1'b1; op = 3'd0; a = 32'd123; b = 32'd456;
        tick;
        start = 1'b0;
        for (int c = 1; c < 20; c++) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        chk("rst_mid_busy",   {31'b0, busy}, 32'd0);
        chk("rst_mid_done",   {31'b0, done}, 32'd0);
        chk("rst_mid_result", result,        32'd0);
        tick;
        do_op(3'd0, 32'd123, 32'd456, 5, res, lat);
        chk("post_rst_result",  res, 32'd56088);
        chk("post_rst_latency", 32'(lat), 32'd34);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
